// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row sense lines in, column drive and key report out.
// The scanner takes the master view; the keypad/debouncer side takes the slave view.
interface keypad_scanner_if;
   logic [3:0] rows;
   logic [3:0] cols;
   logic       pressed;
   logic [3:0] itemp;

   modport master (input rows, output cols, output pressed, output itemp);
   modport slave  (output rows, input cols, input pressed, input itemp);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, locks onto the first key seen
// and reports its code with a level pressed flag until that row releases.
module keypad_scanner #(
   parameter int SETTLE_CYCLES = 1200,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             int_osc,
   input  logic             reset,
   keypad_scanner_if.master kp
);
   localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [0:0]       ST_SCAN  = 1'b0;
   localparam logic [0:0]       ST_HOLD  = 1'b1;

   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   logic [3:0]                  rows_s;
   logic [0:0]                  state_q, state_d;
   logic [1:0]                  col_q, col_d;
   logic [1:0]                  row_q, row_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        pressed_q, pressed_d;
   logic [3:0]                  itemp_q, itemp_d;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'h0;
         4'd14:   code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Lowest-index low row wins when several keys share the sampled column.
   function automatic logic [1:0] first_low(input logic [3:0] r);
      logic [1:0] idx;
      if (!r[0])      idx = 2'd0;
      else if (!r[1]) idx = 2'd1;
      else if (!r[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], kp.rows};
   end

   assign rows_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      cnt_d     = cnt_q;
      pressed_d = pressed_q;
      itemp_d   = itemp_q;
      case (state_q)
         ST_SCAN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (&rows_s) begin
                  col_d = col_q + 2'd1;
               end else begin
                  row_d     = first_low(rows_s);
                  itemp_d   = key_code(first_low(rows_s), col_q);
                  pressed_d = 1'b1;
                  state_d   = ST_HOLD;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            // Only the locked row matters; any single high sample ends the hold.
            if (rows_s[row_q]) begin
               pressed_d = 1'b0;
               col_d     = col_q + 2'd1;
               cnt_d     = '0;
               state_d   = ST_SCAN;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         sync_q    <= '1;
         state_q   <= ST_SCAN;
         col_q     <= 2'd0;
         row_q     <= 2'd0;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         itemp_q   <= 4'h0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         itemp_q   <= itemp_d;
      end
   end

   assign kp.cols    = ~(4'b0001 << col_q);
   assign kp.pressed = pressed_q;
   assign kp.itemp   = itemp_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model plus directed and
// randomized press/hold/release scenarios checked against the key map and timing rules.
module tb_keypad_scanner;
   localparam int SETTLE = 8;
   localparam int SYNC   = 2;
   localparam int LOCK_MAX = 4 * SETTLE + SYNC;

   logic       clk;
   logic       rst_n;
   logic [15:0] held;
   logic [3:0] hi_mask;
   logic [3:0] lo_mask;
   logic [3:0] rows_model;
   int         errors;
   int         checks;

   logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

   keypad_scanner_if kp_if ();

   keypad_scanner #(.SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)) dut (
      .int_osc (clk),
      .reset   (rst_n),
      .kp      (kp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical matrix: a held key pulls its row low only while its column is driven.
   always_comb begin
      rows_model = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (held[r*4+c] && !kp_if.cols[c]) rows_model[r] = 1'b0;
      rows_model = (rows_model | hi_mask) & ~lo_mask;
   end
   assign kp_if.rows = rows_model;

   function automatic logic [3:0] col_drive(input int c);
      logic [3:0] v;
      v = 4'b1111;
      v[c % 4] = 1'b0;
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ($countones(~kp_if.cols) != 1) begin
            errors++;
            $display("FAIL cols_onehot: got %b, required exactly one zero", kp_if.cols);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      held    = '0;
      hi_mask = '0;
      lo_mask = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_level(input logic lvl, input int max_edges, output int n);
      n = 0;
      while (n < max_edges) begin
         @(posedge clk);
         #1;
         n++;
         if (kp_if.pressed === lvl) return;
      end
      n = max_edges + 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (kp_if.cols !== 4'b1110 || kp_if.pressed !== 1'b0 || kp_if.itemp !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: got cols=%b pressed=%b itemp=%h, required 1110/0/0",
                  kp_if.cols, kp_if.pressed, kp_if.itemp);
      end
   endtask

   task automatic test_idle_scan();
      logic [3:0] exp;
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         exp = col_drive(k / SETTLE);
         checks++;
         if (kp_if.cols !== exp || kp_if.pressed !== 1'b0 || kp_if.itemp !== 4'h0) begin
            errors++;
            $display("FAIL idle_scan edge %0d: got cols=%b pressed=%b itemp=%h, required %b/0/0",
                     k, kp_if.cols, kp_if.pressed, kp_if.itemp, exp);
         end
      end
   endtask

   task automatic test_single_key();
      int n;
      do_reset();
      held[1*4+2] = 1'b1;
      wait_level(1'b1, LOCK_MAX + 4, n);
      checks++;
      if (n > LOCK_MAX || kp_if.itemp !== key_tab[6] || kp_if.cols !== 4'b1011) begin
         errors++;
         $display("FAIL single_lock: got edges=%0d itemp=%h cols=%b, required <=%0d/6/1011",
                  n, kp_if.itemp, kp_if.cols, LOCK_MAX);
      end
      repeat (50) @(posedge clk);
      #1;
      checks++;
      if (kp_if.pressed !== 1'b1 || kp_if.cols !== 4'b1011) begin
         errors++;
         $display("FAIL single_hold: got pressed=%b cols=%b, required 1/1011", kp_if.pressed, kp_if.cols);
      end
      @(negedge clk);
      held = '0;
      wait_level(1'b0, 6, n);
      checks++;
      if (n != SYNC + 1 || kp_if.cols !== 4'b0111 || kp_if.itemp !== 4'h6) begin
         errors++;
         $display("FAIL single_release: got edges=%0d cols=%b itemp=%h, required 3/0111/6",
                  n, kp_if.cols, kp_if.itemp);
      end
   endtask

   task automatic test_two_keys();
      int n;
      do_reset();
      held[2*4+0] = 1'b1;
      held[3*4+0] = 1'b1;
      wait_level(1'b1, LOCK_MAX + 4, n);
      checks++;
      if (n > LOCK_MAX || kp_if.itemp !== 4'h7) begin
         errors++;
         $display("FAIL two_keys_lock: got edges=%0d itemp=%h, required <=%0d/7", n, kp_if.itemp, LOCK_MAX);
      end
      @(negedge clk);
      held[3*4+0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (kp_if.pressed !== 1'b1 || kp_if.itemp !== 4'h7) begin
         errors++;
         $display("FAIL two_keys_other_release: got pressed=%b itemp=%h, required 1/7",
                  kp_if.pressed, kp_if.itemp);
      end
      @(negedge clk);
      held[2*4+0] = 1'b0;
      wait_level(1'b0, 6, n);
      checks++;
      if (n != SYNC + 1) begin
         errors++;
         $display("FAIL two_keys_release: got edges=%0d, required %0d", n, SYNC + 1);
      end
   endtask

   task automatic test_bounce();
      int n_drop;
      int n_relock;
      do_reset();
      held[3*4+1] = 1'b1;
      wait_level(1'b1, LOCK_MAX + 4, n_relock);
      checks++;
      if (kp_if.pressed !== 1'b1 || kp_if.itemp !== 4'h0 || kp_if.cols !== 4'b1101) begin
         errors++;
         $display("FAIL bounce_lock: got pressed=%b itemp=%h cols=%b, required 1/0/1101",
                  kp_if.pressed, kp_if.itemp, kp_if.cols);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      hi_mask[3] = 1'b1;
      @(negedge clk);
      hi_mask[3] = 1'b0;
      wait_level(1'b0, 6, n_drop);
      checks++;
      if (n_drop != SYNC) begin
         errors++;
         $display("FAIL bounce_drop: got edges after restore=%0d, required %0d", n_drop, SYNC);
      end
      wait_level(1'b1, LOCK_MAX + 4, n_relock);
      checks++;
      if (n_drop + n_relock > LOCK_MAX || kp_if.itemp !== 4'h0 || kp_if.cols !== 4'b1101) begin
         errors++;
         $display("FAIL bounce_relock: got edges=%0d itemp=%h cols=%b, required <=%0d/0/1101",
                  n_drop + n_relock, kp_if.itemp, kp_if.cols, LOCK_MAX);
      end
      @(negedge clk);
      held = '0;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      held[3*4+3] = 1'b1;
      wait_level(1'b1, LOCK_MAX + 4, n);
      checks++;
      if (kp_if.itemp !== 4'hD || kp_if.cols !== 4'b0111) begin
         errors++;
         $display("FAIL areset_lock: got itemp=%h cols=%b, required D/0111", kp_if.itemp, kp_if.cols);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (kp_if.cols !== 4'b1110 || kp_if.pressed !== 1'b0 || kp_if.itemp !== 4'h0) begin
         errors++;
         $display("FAIL areset_immediate: got cols=%b pressed=%b itemp=%h, required 1110/0/0",
                  kp_if.cols, kp_if.pressed, kp_if.itemp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SETTLE - 1) @(posedge clk);
      #1;
      checks++;
      if (kp_if.cols !== 4'b1110 || kp_if.pressed !== 1'b0) begin
         errors++;
         $display("FAIL areset_resume_col0: got cols=%b pressed=%b, required 1110/0", kp_if.cols, kp_if.pressed);
      end
      @(posedge clk);
      #1;
      checks++;
      if (kp_if.cols !== 4'b1101) begin
         errors++;
         $display("FAIL areset_resume_col1: got cols=%b, required 1101", kp_if.cols);
      end
      @(negedge clk);
      held = '0;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_glitch();
      int n;
      do_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      lo_mask[0] = 1'b1;
      repeat (2) @(negedge clk);
      lo_mask[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (kp_if.pressed !== 1'b0 || kp_if.cols !== 4'b1101) begin
         errors++;
         $display("FAIL glitch_ignored: got pressed=%b cols=%b, required 0/1101", kp_if.pressed, kp_if.cols);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      lo_mask[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (kp_if.pressed !== 1'b1 || kp_if.itemp !== 4'h2 || kp_if.cols !== 4'b1101) begin
         errors++;
         $display("FAIL glitch_sampled: got pressed=%b itemp=%h cols=%b, required 1/2/1101",
                  kp_if.pressed, kp_if.itemp, kp_if.cols);
      end
      @(negedge clk);
      lo_mask[0] = 1'b0;
      wait_level(1'b0, 6, n);
      checks++;
      if (n != SYNC + 1) begin
         errors++;
         $display("FAIL glitch_release: got edges=%0d, required %0d", n, SYNC + 1);
      end
   endtask

   task automatic test_random();
      int n;
      int key;
      int c;
      do_reset();
      for (int it = 0; it < 12; it++) begin
         repeat ($urandom_range(0, 20)) @(posedge clk);
         key = $urandom_range(0, 15);
         c   = key % 4;
         @(negedge clk);
         held[key] = 1'b1;
         wait_level(1'b1, LOCK_MAX + 4, n);
         checks++;
         if (n > LOCK_MAX || kp_if.itemp !== key_tab[key] || kp_if.cols !== col_drive(c)) begin
            errors++;
            $display("FAIL rand_lock key %0d: got edges=%0d itemp=%h cols=%b, required <=%0d/%h/%b",
                     key, n, kp_if.itemp, kp_if.cols, LOCK_MAX, key_tab[key], col_drive(c));
         end
         repeat ($urandom_range(3, 40)) @(posedge clk);
         #1;
         checks++;
         if (kp_if.pressed !== 1'b1 || kp_if.cols !== col_drive(c)) begin
            errors++;
            $display("FAIL rand_hold key %0d: got pressed=%b cols=%b, required 1/%b",
                     key, kp_if.pressed, kp_if.cols, col_drive(c));
         end
         @(negedge clk);
         held = '0;
         wait_level(1'b0, 6, n);
         checks++;
         if (n != SYNC + 1 || kp_if.cols !== col_drive(c + 1) || kp_if.itemp !== key_tab[key]) begin
            errors++;
            $display("FAIL rand_release key %0d: got edges=%0d cols=%b itemp=%h, required %0d/%b/%h",
                     key, n, kp_if.cols, kp_if.itemp, SYNC + 1, col_drive(c + 1), key_tab[key]);
         end
      end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b1;
      held    = '0;
      hi_mask = '0;
      lo_mask = '0;
      test_reset();
      test_idle_scan();
      test_single_key();
      test_two_keys();
      test_bounce();
      test_async_reset();
      test_glitch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
